// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   state_e      controller state encoding (RUN / DRAIN / HALTED)
//   pipe_ctrl_t  bundle of pipeline-register enables and NOP-insert controls
//   NOP_INSTR    instruction word loaded into IF/ID or ID/EX on flush/bubble
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    // Encoding of the NOP that the pipeline registers load on flush/bubble.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_bubble;
        logic exmem_we;
        logic memwb_we;
    } pipe_ctrl_t;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp
// Purely combinational RAW hazard detection for the instruction in ID.
// Build option: HAZARD_FWD_EN
//   defined   - EX/MEM->EX forwarding exists; only a load in EX whose
//               destination matches a used ID source raises raw (load-use).
//   undefined - any EX or MEM destination match with write enable raises raw.
// Ports:
//   id_r1_num/id_r2_num    in  ID source register numbers
//   id_r1_used/id_r2_used  in  ID instruction reads the source
//   ex_reg_write_num/en    in  EX destination and write enable
//   ex_mem_read            in  EX instruction is a load
//   mem_reg_write_num/en   in  MEM destination and write enable
//   raw                    out read-after-write hazard present
// -----------------------------------------------------------------------------
module hazard_cmp (
    input  logic [2:0] id_r1_num,
    input  logic [2:0] id_r2_num,
    input  logic       id_r1_used,
    input  logic       id_r2_used,
    input  logic [2:0] ex_reg_write_num,
    input  logic       ex_reg_write_en,
    input  logic       ex_mem_read,
    input  logic [2:0] mem_reg_write_num,
    input  logic       mem_reg_write_en,
    output logic       raw
);

    logic ex_hit;

    assign ex_hit = ex_reg_write_en &
                    ((id_r1_used & (ex_reg_write_num == id_r1_num)) |
                     (id_r2_used & (ex_reg_write_num == id_r2_num)));

`ifdef HAZARD_FWD_EN
    // MEM results are forwarded, so the MEM destination never causes a stall.
    logic [3:0] unused_mem_dest;
    assign unused_mem_dest = {mem_reg_write_en, mem_reg_write_num};

    assign raw = ex_hit & ex_mem_read;
`else
    // Without forwarding every pending write stalls; the load flag is irrelevant.
    logic unused_ex_mem_read;
    logic mem_hit;
    assign unused_ex_mem_read = ex_mem_read;

    assign mem_hit = mem_reg_write_en &
                     ((id_r1_used & (mem_reg_write_num == id_r1_num)) |
                      (id_r2_used & (mem_reg_write_num == id_r2_num)));

    assign raw = ex_hit | mem_hit;
`endif

endmodule : hazard_cmp

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard/stall/flush controller for the 5-stage 16-bit pipeline. Produces the
// write enables of PC, IF/ID, ID/EX, EX/MEM, MEM/WB and the NOP-insert controls
// of IF/ID and ID/EX, sequences the halt drain, and keeps a saturating count of
// RUN cycles in which the PC was held (debug).
// Build option: HAZARD_FWD_EN (see hazard_cmp) selects load-use-only stalls.
// Parameters:
//   DRAIN_DEPTH  advancing cycles from HALT entering ID/EX until halted
//   CNT_W        width of stall_cnt
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_*                           ID-stage sources and HALT flag
//   ex_*, mem_*                    EX/MEM destinations, load flag, branch taken
//   imem_stall, dmem_stall         memory not-ready indications
//   pc_we ... memwb_we             pipeline register controls (combinational)
//   halted                         core halted (registered)
//   stall_cnt                      saturating held-PC cycle count (registered)
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_DEPTH = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_r1Num,
    input  logic [2:0]       id_r2Num,
    input  logic             id_r1Used,
    input  logic             id_r2Used,
    input  logic             id_halt,
    input  logic [2:0]       ex_regWriteNum,
    input  logic             ex_regWriteEn,
    input  logic             ex_memRead,
    input  logic [2:0]       mem_regWriteNum,
    input  logic             mem_regWriteEn,
    input  logic             ex_brTaken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DRAIN_W = $clog2(DRAIN_DEPTH + 1);

    state_e             state_q,     state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               halted_q,    halted_d;

    logic       raw;
    logic       halt_accept;
    pipe_ctrl_t ctrl;

    hazard_cmp u_hazard_cmp (
        .id_r1_num         (id_r1Num),
        .id_r2_num         (id_r2Num),
        .id_r1_used        (id_r1Used),
        .id_r2_used        (id_r2Used),
        .ex_reg_write_num  (ex_regWriteNum),
        .ex_reg_write_en   (ex_regWriteEn),
        .ex_mem_read       (ex_memRead),
        .mem_reg_write_num (mem_regWriteNum),
        .mem_reg_write_en  (mem_regWriteEn),
        .raw               (raw)
    );

    // Pipeline controls: combinational from state and inputs, taking effect at
    // the next edge.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        ctrl          = '0;
        ctrl.exmem_we = ~dmem_stall;
        ctrl.memwb_we = ~dmem_stall;

        unique case (state_q)
            ST_RUN: begin
                if (dmem_stall) begin
                    ctrl = '0;                          // full freeze
                end else if (ex_brTaken) begin
                    ctrl.pc_we       = 1'b1;
                    ctrl.ifid_we     = 1'b1;
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_we     = 1'b1;
                    ctrl.idex_bubble = 1'b1;
                end else if (raw) begin
                    // Hold PC and IF/ID so the ID instruction repeats.
                    ctrl.idex_we     = 1'b1;
                    ctrl.idex_bubble = 1'b1;
                end else if (imem_stall) begin
                    ctrl.ifid_we     = 1'b1;
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_we     = 1'b1;
                end else begin
                    ctrl.pc_we   = 1'b1;
                    ctrl.ifid_we = 1'b1;
                    ctrl.idex_we = 1'b1;
                end
            end
            ST_DRAIN: begin
                ctrl.idex_we     = 1'b1;
                ctrl.idex_bubble = 1'b1;
            end
            default: begin
                ctrl = '0;                              // HALTED: everything frozen
            end
        endcase
    end

    // A HALT is accepted only when it actually moves into ID/EX as itself.
    assign halt_accept = (state_q == ST_RUN) & id_halt & ctrl.idex_we & ~ctrl.idex_bubble;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        stall_cnt_d = stall_cnt_q;

        unique case (state_q)
            ST_RUN: begin
                // Freeze cycles are not counted; only cycles where the front end
                // is held while the back end advances.
                if (!ctrl.pc_we && !dmem_stall && (stall_cnt_q != '1)) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
                if (halt_accept) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_W'(DRAIN_DEPTH);
                end
            end
            ST_DRAIN: begin
                if (!dmem_stall) begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                    if (drain_cnt_q == DRAIN_W'(1)) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase

        halted_d = (state_d == ST_HALTED);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            halted_q    <= halted_d;
        end
    end

    assign pc_we       = ctrl.pc_we;
    assign ifid_we     = ctrl.ifid_we;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_we     = ctrl.idex_we;
    assign idex_bubble = ctrl.idex_bubble;
    assign exmem_we    = ctrl.exmem_we;
    assign memwb_we    = ctrl.memwb_we;
    assign halted      = halted_q;
    assign stall_cnt   = stall_cnt_q;

endmodule : hazard_ctrl
